// File: rtl/phase_sweep_controller.sv
// Linear frequency-sweep sequencer for a phase accumulator: zeroes the phase,
// then steps the phase increment from start_step to stop_step with a dwell per step.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; config registers hold the last sweep
// LOAD_PHASE | offering phase 0 on the phase-load stream
// SEND_STEP  | offering cur on the phase-step stream
// DWELL      | counting down cnt, then choosing the next step or finishing
// DONE       | one-cycle completion pulse
module phase_sweep_controller #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       start_step,
    input  logic [WIDTH-1:0]       stop_step,
    input  logic [WIDTH-1:0]       step_increment,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   repeat_mode,
    input  logic                   start,
    input  logic                   abort,
    output logic [WIDTH-1:0]       output_phase_tdata,
    output logic                   output_phase_tvalid,
    input  logic                   output_phase_tready,
    output logic [WIDTH-1:0]       output_phase_step_tdata,
    output logic                   output_phase_step_tvalid,
    input  logic                   output_phase_step_tready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_PHASE = 3'd1,
        S_SEND_STEP  = 3'd2,
        S_DWELL      = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]       cfg_start_step;
    logic [WIDTH-1:0]       cfg_stop_step;
    logic [WIDTH-1:0]       cfg_increment;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   cfg_repeat;
    logic [WIDTH-1:0]       cur;
    logic [DWELL_WIDTH-1:0] cnt;
    logic                   abort_flag;

    logic             start_accept;
    logic             phase_xfer;
    logic             step_xfer;
    logic             abort_any;
    logic             end_cond;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cur_adv;

    assign start_accept = (state == S_IDLE) && start && !abort;
    assign phase_xfer   = output_phase_tvalid && output_phase_tready;
    assign step_xfer    = output_phase_step_tvalid && output_phase_step_tready;
    assign abort_any    = abort || abort_flag;
    assign end_cond     = (cur >= cfg_stop_step) || (cfg_increment == '0);

    // Extra carry bit: a sum that overflows WIDTH counts as past stop_step, so it clamps.
    assign sum     = {1'b0, cur} + {1'b0, cfg_increment};
    assign cur_adv = (sum > {1'b0, cfg_stop_step}) ? cfg_stop_step : sum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_accept) begin
                    state_nxt = S_LOAD_PHASE;
                end
            end
            S_LOAD_PHASE: begin
                if (phase_xfer) begin
                    state_nxt = abort_any ? S_IDLE : S_SEND_STEP;
                end
            end
            S_SEND_STEP: begin
                if (step_xfer) begin
                    state_nxt = abort_any ? S_IDLE : S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    if (end_cond && !cfg_repeat) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SEND_STEP;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_start_step <= '0;
            cfg_stop_step  <= '0;
            cfg_increment  <= '0;
            cfg_dwell      <= '0;
            cfg_repeat     <= 1'b0;
            cur            <= '0;
            cnt            <= '0;
            abort_flag     <= 1'b0;
        end else begin
            if (start_accept) begin
                cfg_start_step <= start_step;
                cfg_stop_step  <= stop_step;
                cfg_increment  <= step_increment;
                cfg_dwell      <= dwell;
                cfg_repeat     <= repeat_mode;
            end

            if ((state == S_LOAD_PHASE) && phase_xfer) begin
                cur <= cfg_start_step;
            end else if ((state == S_DWELL) && (cnt == '0) && !abort) begin
                if (end_cond) begin
                    if (cfg_repeat) begin
                        cur <= cfg_start_step;
                    end
                end else begin
                    cur <= cur_adv;
                end
            end

            if ((state == S_SEND_STEP) && step_xfer) begin
                cnt <= cfg_dwell;
            end else if ((state == S_DWELL) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            // Abort during a handshake waits for the transfer; the flag remembers it.
            if (state_nxt == S_IDLE) begin
                abort_flag <= 1'b0;
            end else if (abort && ((state == S_LOAD_PHASE) || (state == S_SEND_STEP))) begin
                abort_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        output_phase_tdata       = '0;
        output_phase_tvalid      = (state == S_LOAD_PHASE);
        output_phase_step_tdata  = cur;
        output_phase_step_tvalid = (state == S_SEND_STEP);
        busy                     = (state != S_IDLE);
        done                     = (state == S_DONE) && !abort;
    end

endmodule
